// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/ADDU/SUBU/ORI plus iterative MULTU/DIVU writing HI/LO.
// Define ALU_EXEC_MULDIV_EN to build the multiply/divide datapath; otherwise MULTU/DIVU are illegal.
`ifndef ALU_CONLROL_LENGTH
`define ALU_CONLROL_LENGTH 4
`endif
`ifndef ALU_CONLROL_ADD
`define ALU_CONLROL_ADD   4'h0
`define ALU_CONLROL_ADDU  4'h1
`define ALU_CONLROL_SUBU  4'h2
`define ALU_CONLROL_ORI   4'h3
`define ALU_CONLROL_MULTU 4'h4
`define ALU_CONLROL_DIVU  4'h5
`endif

module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [`ALU_CONLROL_LENGTH-1:0] alu_conlrol,
    input  logic [WIDTH-1:0]               src_a,
    input  logic [WIDTH-1:0]               src_b,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               result,
    output logic                           ovf,
    output logic                           div_zero,
    output logic                           illegal,
    output logic [WIDTH-1:0]               hi,
    output logic [WIDTH-1:0]               lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic             ill_q, ill_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] sum;
    logic             accept;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign sum      = src_a + src_b;

`ifdef ALU_EXEC_MULDIV_EN
    localparam int CW = $clog2(WIDTH);

    // acc holds {upper partial product, shifting multiplier} or {remainder, shifting quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic               last_iter;

    assign mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_upper, acc_q[WIDTH-1:1]};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        ill_d       = ill_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
`ifdef ALU_EXEC_MULDIV_EN
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
`endif
        if (accept) begin
            ovf_d = 1'b0;
            dz_d  = 1'b0;
            ill_d = 1'b0;
            case (alu_conlrol)
                `ALU_CONLROL_ADD: begin
                    result_d    = sum;
                    ovf_d       = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                                  (sum[WIDTH-1] != src_a[WIDTH-1]);
                    out_valid_d = 1'b1;
                end
                `ALU_CONLROL_ADDU: begin
                    result_d    = sum;
                    out_valid_d = 1'b1;
                end
                `ALU_CONLROL_SUBU: begin
                    result_d    = src_a - src_b;
                    out_valid_d = 1'b1;
                end
                `ALU_CONLROL_ORI: begin
                    result_d    = src_a | src_b;
                    out_valid_d = 1'b1;
                end
`ifdef ALU_EXEC_MULDIV_EN
                `ALU_CONLROL_MULTU: begin
                    state_d = S_MUL;
                    opnd_d  = src_a;
                    acc_d   = {{WIDTH{1'b0}}, src_b};
                    cnt_d   = '0;
                end
                `ALU_CONLROL_DIVU: begin
                    state_d = S_DIV;
                    opnd_d  = src_b;
                    acc_d   = {{WIDTH{1'b0}}, src_a};
                    cnt_d   = '0;
                end
`endif
                default: begin
                    result_d    = '0;
                    ill_d       = 1'b1;
                    out_valid_d = 1'b1;
                end
            endcase
        end
`ifdef ALU_EXEC_MULDIV_EN
        if (state_q == S_MUL || state_q == S_DIV) begin
            acc_d = (state_q == S_MUL) ? mul_next : div_next;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
                hi_d        = acc_d[2*WIDTH-1:WIDTH];
                lo_d        = acc_d[WIDTH-1:0];
                result_d    = acc_d[WIDTH-1:0];
                dz_d        = (state_q == S_DIV) && (opnd_q == '0);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            ill_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
`ifdef ALU_EXEC_MULDIV_EN
            acc_q       <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            ill_q       <= ill_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
`ifdef ALU_EXEC_MULDIV_EN
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign div_zero  = dz_q;
    assign illegal   = ill_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at issue, compared on out_valid.
`ifndef ALU_CONLROL_LENGTH
`define ALU_CONLROL_LENGTH 4
`endif
`ifndef ALU_CONLROL_ADD
`define ALU_CONLROL_ADD   4'h0
`define ALU_CONLROL_ADDU  4'h1
`define ALU_CONLROL_SUBU  4'h2
`define ALU_CONLROL_ORI   4'h3
`define ALU_CONLROL_MULTU 4'h4
`define ALU_CONLROL_DIVU  4'h5
`endif

module tb_alu_exec_unit;
    localparam int W = 32;
    localparam logic [`ALU_CONLROL_LENGTH-1:0] OP_ADD   = `ALU_CONLROL_ADD;
    localparam logic [`ALU_CONLROL_LENGTH-1:0] OP_ADDU  = `ALU_CONLROL_ADDU;
    localparam logic [`ALU_CONLROL_LENGTH-1:0] OP_SUBU  = `ALU_CONLROL_SUBU;
    localparam logic [`ALU_CONLROL_LENGTH-1:0] OP_ORI   = `ALU_CONLROL_ORI;
    localparam logic [`ALU_CONLROL_LENGTH-1:0] OP_MULTU = `ALU_CONLROL_MULTU;
    localparam logic [`ALU_CONLROL_LENGTH-1:0] OP_DIVU  = `ALU_CONLROL_DIVU;
    localparam logic [`ALU_CONLROL_LENGTH-1:0] OP_BAD   = 7;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           in_valid;
    logic                           in_ready;
    logic [`ALU_CONLROL_LENGTH-1:0] alu_conlrol;
    logic [W-1:0]                   src_a, src_b;
    logic                           out_valid;
    logic [W-1:0]                   result;
    logic                           ovf, div_zero, illegal;
    logic [W-1:0]                   hi, lo;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_conlrol(alu_conlrol), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .result(result), .ovf(ovf), .div_zero(div_zero),
        .illegal(illegal), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         dz;
        logic         ill;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [`ALU_CONLROL_LENGTH-1:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] s;
        logic [63:0]  p;
        e.res = '0; e.ovf = 1'b0; e.dz = 1'b0; e.ill = 1'b0;
        e.hi = m_hi; e.lo = m_lo; e.lat = 1; e.acc_cyc = 0;
        s = a + b;
        if (op == OP_ADD) begin
            e.res = s;
            e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else if (op == OP_ADDU) e.res = s;
        else if (op == OP_SUBU) e.res = a - b;
        else if (op == OP_ORI)  e.res = a | b;
`ifdef ALU_EXEC_MULDIV_EN
        else if (op == OP_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            e.hi = p[63:32]; e.lo = p[31:0]; e.res = p[31:0]; e.lat = W + 1;
        end else if (op == OP_DIVU) begin
            if (b == 0) begin
                e.lo = '1; e.hi = a; e.dz = 1'b1;
            end else begin
                e.lo = a / b; e.hi = a % b;
            end
            e.res = e.lo; e.lat = W + 1;
        end
`endif
        else e.ill = 1'b1;
        return e;
    endfunction

    task automatic issue(input logic [`ALU_CONLROL_LENGTH-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit push);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; alu_conlrol = op; src_a = a; src_b = b;
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            check("ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e = model(op, a, b);
            e.acc_cyc = cyc;
            m_hi = e.hi; m_lo = e.lo;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            check("ov_unexpected", 64'(out_valid), (sbq.size() > 0) ? 64'd1 : 64'd0);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("result",   64'(result),   64'(e.res));
                check("ovf",      64'(ovf),      64'(e.ovf));
                check("div_zero", 64'(div_zero), 64'(e.dz));
                check("illegal",  64'(illegal),  64'(e.ill));
                check("hi",       64'(hi),       64'(e.hi));
                check("lo",       64'(lo),       64'(e.lo));
                check("latency",  64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge clk);
        check("drain_pending", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        logic [`ALU_CONLROL_LENGTH-1:0] ops [7];
        int n;
        ops = '{OP_ADD, OP_ADDU, OP_SUBU, OP_ORI, OP_MULTU, OP_DIVU, OP_BAD};
        rst = 1'b1; in_valid = 1'b0; alu_conlrol = '0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_flags",     64'({ovf, div_zero, illegal}), 64'd0);
        check("rst_hi",        64'(hi), 64'd0);
        check("rst_lo",        64'(lo), 64'd0);
        rst = 1'b0;

        issue(OP_ADDU, 32'hFFFF_FFFF, 32'h1, 1'b1);
        issue(OP_ADD,  32'h7FFF_FFFF, 32'h1, 1'b1);
        issue(OP_ORI,  32'hF0, 32'h0F, 1'b1);
        issue(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 1'b1);
        issue(OP_ADD,  32'h8000_0000, 32'h8000_0000, 1'b1);
        issue(OP_SUBU, 32'h5, 32'h7, 1'b1);
        issue(OP_BAD,  32'h1234, 32'h5678, 1'b1);
        drain();

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b1);
`ifdef ALU_EXEC_MULDIV_EN
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check("mul_busy_cycles", 64'(n), 64'(W));
`endif
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        issue(OP_DIVU, 32'd5, 32'd0, 1'b1);
        issue(OP_ADD, 32'h1, 32'h2, 1'b1);
        drain();

`ifdef ALU_EXEC_MULDIV_EN
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
`else
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b1);
`endif
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        sbq.delete();
        @(negedge clk);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_hi",        64'(hi), 64'd0);
        check("abort_lo",        64'(lo), 64'd0);
        repeat (40) @(negedge clk);

        // Hold in_valid through the whole busy period; only one completion may appear.
        in_valid = 1'b1; alu_conlrol = OP_DIVU; src_a = 32'd77; src_b = 32'd10;
        begin
            exp_t e;
            e = model(OP_DIVU, 32'd77, 32'd10);
            e.acc_cyc = cyc;
            m_hi = e.hi; m_lo = e.lo;
            sbq.push_back(e);
        end
        @(posedge clk);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        in_valid = 1'b0;
        repeat (45) @(negedge clk);
        check("held_queue", 64'(sbq.size()), 64'd0);

        issue(OP_MULTU, 32'd3, 32'd4, 1'b1);
        drain();

        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (k % 5 == 0) ? '0 : ((k % 3 == 0) ? 32'(k) : W'($urandom));
            issue(ops[$urandom_range(0, 6)], a, b, 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
